// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit between the RV32I datapath and a word-wide data memory
// that has no byte enables. Sub-word loads are extracted and extended here.
// Sub-word stores are done as read-modify-write. Illegal, misaligned and
// out-of-range accesses are answered with an error and never touch memory.
module lsu_dmem_ctrl #(
    parameter int unsigned DMEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_RD  = 3'd1,
        LD_EXT = 3'd2,
        ST_W   = 3'd3,
        RMW_RD = 3'd4,
        RMW_WR = 3'd5
    } state_t;

    localparam logic [31:0] DMEM_LIMIT = 32'(DMEM_BYTES);

    // Pick the addressed byte/half out of a memory word and extend it per funct3.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        if (off[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'h000000, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'h0000, h};
            3'b010:  r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/half of a memory word with store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3,
                                                input logic [31:0] wd);
        logic [31:0] r;
        r = word;
        case (f3)
            3'b000: begin
                case (off)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    2'd3:    r[31:24] = wd[7:0];
                    default: r = word;
                endcase
            end
            3'b001: begin
                if (off[1]) begin
                    r[31:16] = wd[15:0];
                end else begin
                    r[15:0] = wd[15:0];
                end
            end
            default: r = word;
        endcase
        return r;
    endfunction

    state_t      state_r;
    state_t      state_n_s;
    logic [31:0] addr_r;
    logic [2:0]  funct3_r;
    logic [31:0] wdata_r;

    logic        accept_s;
    logic        f3_ok_s;
    logic        misalign_s;
    logic        req_err_s;

    logic        resp_valid_n_s;
    logic        resp_err_n_s;
    logic [31:0] resp_rdata_n_s;
    logic        resp_valid_r;
    logic        resp_err_r;
    logic [31:0] resp_rdata_r;

    assign accept_s = req_valid && (state_r == IDLE);

    // Classify the incoming request: legal funct3 for its direction, alignment, range.
    always_comb begin
        f3_ok_s    = 1'b0;
        misalign_s = 1'b0;
        case (req_funct3)
            3'b000: f3_ok_s = 1'b1;
            3'b001: begin
                f3_ok_s    = 1'b1;
                misalign_s = req_addr[0];
            end
            3'b010: begin
                f3_ok_s    = 1'b1;
                misalign_s = |req_addr[1:0];
            end
            3'b100: f3_ok_s = !req_we;
            3'b101: begin
                f3_ok_s    = !req_we;
                misalign_s = req_addr[0];
            end
            default: f3_ok_s = 1'b0;
        endcase
        req_err_s = !f3_ok_s || misalign_s || (req_addr >= DMEM_LIMIT);
    end

    // Next-state logic and memory-side outputs decoded from the current state.
    always_comb begin
        state_n_s = state_r;
        req_ready = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0000_0000;
        mem_wd    = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                req_ready = 1'b1;
                if (accept_s && !req_err_s) begin
                    if (!req_we) begin
                        state_n_s = LD_RD;
                    end else if (req_funct3 == 3'b010) begin
                        state_n_s = ST_W;
                    end else begin
                        state_n_s = RMW_RD;
                    end
                end else begin
                    state_n_s = IDLE;
                end
            end
            LD_RD: begin
                mem_addr  = {addr_r[31:2], 2'b00};
                state_n_s = LD_EXT;
            end
            LD_EXT: begin
                mem_addr  = {addr_r[31:2], 2'b00};
                state_n_s = IDLE;
            end
            ST_W: begin
                mem_we    = 1'b1;
                mem_addr  = {addr_r[31:2], 2'b00};
                mem_wd    = wdata_r;
                state_n_s = IDLE;
            end
            RMW_RD: begin
                mem_addr  = {addr_r[31:2], 2'b00};
                state_n_s = RMW_WR;
            end
            RMW_WR: begin
                mem_we    = 1'b1;
                mem_addr  = {addr_r[31:2], 2'b00};
                mem_wd    = store_merge(mem_rd, addr_r[1:0], funct3_r, wdata_r);
                state_n_s = IDLE;
            end
            default: state_n_s = IDLE;
        endcase
    end

    // Response for the coming edge: errors answer at accept, accesses on their last state.
    always_comb begin
        resp_valid_n_s = 1'b0;
        resp_err_n_s   = 1'b0;
        resp_rdata_n_s = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                if (accept_s && req_err_s) begin
                    resp_valid_n_s = 1'b1;
                    resp_err_n_s   = 1'b1;
                end else begin
                    resp_valid_n_s = 1'b0;
                end
            end
            LD_EXT: begin
                resp_valid_n_s = 1'b1;
                resp_rdata_n_s = load_extract(mem_rd, addr_r[1:0], funct3_r);
            end
            ST_W:    resp_valid_n_s = 1'b1;
            RMW_WR:  resp_valid_n_s = 1'b1;
            default: resp_valid_n_s = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Capture the request fields on accept; only these are used afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r   <= 32'h0000_0000;
            funct3_r <= 3'b000;
            wdata_r  <= 32'h0000_0000;
        end else if (accept_s) begin
            addr_r   <= req_addr;
            funct3_r <= req_funct3;
            wdata_r  <= req_wdata;
        end
    end

    // Registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
        end else begin
            resp_valid_r <= resp_valid_n_s;
            resp_err_r   <= resp_err_n_s;
            resp_rdata_r <= resp_rdata_n_s;
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;

endmodule
